// File: rtl/ram_rw_bist.sv
// ram_rw_bist: fill/read-back/compare self-test engine for a single-port block RAM
module ram_rw_bist #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 8,
  parameter int RD_LATENCY = 1,
  parameter int ERR_W      = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] seed,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [ADDR_W-1:0] first_err_addr
);
  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;
  localparam logic [2*DATA_W-1:0] CB2 = {DATA_W{2'b01}};
  localparam logic [DATA_W-1:0] CB = CB2[DATA_W-1:0];
  state_t state, state_nxt;
  logic [1:0] mode_q;
  logic [DATA_W-1:0] seed_q, wdata_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic en_nxt, we_nxt, dr_cnt, dr_nxt, mism, ferr;
  logic [ERR_W-1:0] err_nxt;
  logic [RD_LATENCY-1:0] pv;
  logic [DATA_W-1:0] pd [RD_LATENCY];
  logic [ADDR_W-1:0] pa [RD_LATENCY];
  wire accept = (state == IDLE) && start;

  function automatic logic [DATA_W-1:0] pat(input logic [1:0] m, input logic [DATA_W-1:0] s,
                                            input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] ax;
    ax = DATA_W'(a);
    return m == 2'd0 ? ax + s :
           m == 2'd1 ? (a[0] ? ~CB : CB) ^ s :
           m == 2'd2 ? ~ax ^ s : s;
  endfunction

  // next state and next values of the registered RAM-side outputs
  always_comb begin
    state_nxt = state;
    en_nxt = 1'b0;
    we_nxt = 1'b0;
    addr_nxt = '0;
    wdata_nxt = '0;
    dr_nxt = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_nxt = WRITE;
        en_nxt = 1'b1;
        we_nxt = 1'b1;
        wdata_nxt = pat(mode, seed, '0);
      end
      WRITE: begin
        en_nxt = 1'b1;
        if (ram_addr == '1) state_nxt = READ;
        else begin
          we_nxt = 1'b1;
          addr_nxt = ram_addr + 1'b1;
          wdata_nxt = pat(mode_q, seed_q, ram_addr + 1'b1);
        end
      end
      READ: if (ram_addr == '1) state_nxt = DRAIN;
        else begin
          en_nxt = 1'b1;
          addr_nxt = ram_addr + 1'b1;
        end
      DRAIN: if (dr_cnt == 1'(RD_LATENCY - 1)) state_nxt = DONE;
        else dr_nxt = 1'b1;
      default: state_nxt = IDLE;
    endcase
  end

  // compare the pipeline tail against the returning read data
  always_comb begin
    mism = pv[RD_LATENCY-1] && (ram_rdata != pd[RD_LATENCY-1]);
    err_nxt = (mism && err_cnt != '1) ? err_cnt + 1'b1 : err_cnt;
  end

  // state, RAM port and status registers
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= IDLE;
      {ram_en, ram_we, ram_addr, ram_wdata, busy, done, dr_cnt} <= '0;
    end else begin
      state <= state_nxt;
      ram_en <= en_nxt;
      ram_we <= we_nxt;
      ram_addr <= addr_nxt;
      ram_wdata <= wdata_nxt;
      dr_cnt <= dr_nxt;
      busy <= state_nxt != IDLE;
      done <= state_nxt == DONE;
    end
  end

  // latched test setup and error tracking, held until the next accepted start
  always_ff @(posedge sys_clk) begin
    if (sys_rst || accept) begin
      mode_q <= sys_rst ? '0 : mode;
      seed_q <= sys_rst ? '0 : seed;
      {err_cnt, first_err_addr, pass, ferr} <= '0;
    end else begin
      err_cnt <= err_nxt;
      if (mism && !ferr) begin
        ferr <= 1'b1;
        first_err_addr <= pa[RD_LATENCY-1];
      end
      if (state_nxt == DONE) pass <= err_nxt == '0;
    end
  end

  // expected-data pipeline aligned with the RAM read latency
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      pv <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        pd[i] <= '0;
        pa[i] <= '0;
      end
    end else begin
      pv[0] <= ram_en & ~ram_we;
      pd[0] <= pat(mode_q, seed_q, ram_addr);
      pa[0] <= ram_addr;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
        pa[i] <= pa[i-1];
      end
    end
  end
endmodule
